hash160_arbiter: RTL and testbench
==================================

# hash160_arbiter

Round-robin arbiter and sequencer that shares one Hash160 core (SHA-256 followed by RIPEMD-160) among `NUM_REQ` byte-stream requesters.
- It grants one requester and collects exactly 64 message bytes from it.
- It pulses the core start, waits for the core done with a watchdog, then returns the 160-bit digest to that requester as five 32-bit words.
- It sits between the host-side byte ports and the hash core, replacing per-requester core instances.

## Interface
- `NUM_REQ`, 4: number of requesters (power of two, 2..8).
- `ID_W`, 2: log2(`NUM_REQ`).
- `TIMEOUT`, 1024: maximum WAIT cycles before an error response is issued (≥2).
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i has a byte on its lane.
- `req_data`  in  8*`NUM_REQ`  lane i = bits [8i+7:8i].
- `req_ready`  out  `NUM_REQ`  byte accepted on lane i when valid & ready.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_block`  out  512  message block; byte 0 in [511:504], byte 63 in [7:0].
- `core_done`  in  1  core result valid (single-cycle pulse).
- `core_digest`  in  160  hash result, sampled when `core_done`=1.
- `rsp_valid`  out  1  response beat valid (no backpressure).
- `rsp_id`  out  `ID_W`  requester the beat belongs to.
- `rsp_word`  out  32  digest word.
- `rsp_last`  out  1  final beat of a response.
- `rsp_error`  out  1  beat is a timeout error response.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT, OUT, ERR.
- **IDLE:** if any `req_valid`, grant the first set bit searching upward from `rr_ptr` with wrap. Register `grant`, set `rr_ptr` = (grant+1) mod `NUM_REQ`, clear byte counter, go to LOAD. With no request, stay in IDLE.
- **LOAD:** `req_ready[grant]`=1; all other ready bits are 0.
  - Each accepted byte is written to buffer slot `cnt`, then `cnt` increments.
  - Gaps (valid low) stall without limit; there is no abort.
  - On acceptance of byte 63 (6-bit `cnt` wrap), go to START.
  - Other requesters' valids are ignored and they see no ready.
- **START:** `core_start`=1 for exactly one cycle, then go to WAIT with `timer`=0.
- **WAIT:**
  - If `core_done`: capture `core_digest`, set `word_idx`=0, go to OUT.
  - Else if `timer`==`TIMEOUT`-1: go to ERR.
  - Otherwise increment `timer`.
  - If `core_done` and the timeout fire in the same cycle, done wins.
- **OUT:** `rsp_valid`=1 for 5 consecutive cycles with `rsp_id`=grant.
  - Words are output in order: digest[159:128], [127:96], [95:64], [63:32], [31:0].
  - `rsp_last`=1 on the fifth beat only. Then go to IDLE.
- **ERR:** one beat with `rsp_valid`=1, `rsp_error`=1, `rsp_last`=1, `rsp_word`=0, `rsp_id`=grant. Then go to IDLE.
- `core_done` outside WAIT is ignored.
- `core_block` is driven from the buffer at all times. It is stable from START until the next LOAD writes. The buffer is not cleared between requests; each request fully overwrites all 64 bytes.
- `rsp_word`, `rsp_id`, `rsp_last` and `rsp_error` are 0 whenever `rsp_valid`=0.

## Timing
- **Reset:** state IDLE, `rr_ptr`=0, counters 0, buffer 0. All outputs 0: `req_ready`, `core_start`, `core_block`, `rsp_*`, `busy`.
- **Reset mid-operation:** immediate return to IDLE, partial buffer discarded, any pending response lost, `core_start` low.
- **Grant:** requester valid seen in IDLE at cycle t → LOAD with ready at t+1.
- **Load:** with continuous valid, bytes are accepted at t+1..t+64, `core_start` at t+65, WAIT from t+66.
- **Response:** `core_done` at cycle d (in WAIT) → response beats d+1..d+5, IDLE at d+6, next grant decision at d+6.
- **Error:** no done in WAIT cycles 0..`TIMEOUT`-1 → error beat on the cycle after the last WAIT cycle.
- **Minimum turnaround:** back-to-back request service adds 1 IDLE cycle.

## Test plan
- **Single request:** requester 2 streams bytes 0x00..0x3F continuously; model core returns done 10 cycles after start with digest 0x0123…(160b). Expect:
  - `core_start` exactly at t+65.
  - `core_block`[511:504]=0x00, [7:0]=0x3F.
  - Five beats, `rsp_id`=2, first word 0x01234567, `rsp_last` on beat 5.
- **Round-robin:** all 4 requesters valid from reset. Expect grant order 0,1,2,3,0, and `req_ready` one-hot on the granted lane only.
- **Stalled load:** granted requester drops valid for 20 cycles after byte 10. Expect no `core_start` until byte 63 is accepted, and the byte order in `core_block` is preserved.
- **Timeout:** with `TIMEOUT`=16, the core never asserts done. Expect a single beat with `rsp_error`=1, `rsp_last`=1, `rsp_word`=0, then IDLE and the next requester granted.
- **Done/timeout collision:** `core_done` on the WAIT cycle where `timer`=`TIMEOUT`-1. Expect a normal 5-beat response and no error.
- **Reset mid-LOAD:** deassert `rst_n` after 30 bytes. Expect all outputs 0 and state IDLE. A subsequent request from requester 0 is granted first (`rr_ptr`=0), and its 64 new bytes fully define `core_block`.

Source files
------------

// File: rtl/hash160_arbiter_if.sv
// Bundle of requester byte lanes, hash-core handshake and response channel for hash160_arbiter.
// master = arbiter side, slave = host/core environment.
interface hash160_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 core_start;
    logic [511:0]         core_block;
    logic                 core_done;
    logic [159:0]         core_digest;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_word;
    logic                 rsp_last;
    logic                 rsp_error;
    logic                 busy;

    modport master (
        input  req_valid, req_data, core_done, core_digest,
        output req_ready, core_start, core_block,
        output rsp_valid, rsp_id, rsp_word, rsp_last, rsp_error, busy
    );

    modport slave (
        output req_valid, req_data, core_done, core_digest,
        input  req_ready, core_start, core_block,
        input  rsp_valid, rsp_id, rsp_word, rsp_last, rsp_error, busy
    );
endinterface

// File: rtl/hash160_arbiter.sv
// Round-robin arbiter sharing one Hash160 core among NUM_REQ byte-stream requesters.
// Collects a 64-byte block, runs the core under a watchdog and returns the digest as five words.
//
// state | meaning
// IDLE  | choose next requester, searching upward from rr_ptr with wrap
// LOAD  | accept 64 bytes from the granted lane only
// START | one-cycle core start pulse
// WAIT  | wait for core_done while the watchdog counts
// OUT   | five digest beats to the granted requester
// ERR   | single timeout error beat
module hash160_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    hash160_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT, ERR} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] grant, grant_nx;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nx;
    logic [ID_W-1:0] pick;
    logic            pick_ok;
    logic [5:0]      cnt, cnt_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [2:0]      word_idx, word_idx_nx;
    logic [159:0]    digest;
    logic [511:0]    block;
    logic [7:0]      lane_data;
    logic            lane_valid;
    logic            accept;
    logic            capture;
    logic [31:0]     out_word;
    logic            rsp_active;

    assign lane_data  = bus.req_data[{grant, 3'b000} +: 8];
    assign lane_valid = bus.req_valid[grant];
    assign accept     = (state == LOAD) && lane_valid;
    assign capture    = (state == WAIT) && bus.core_done;

    // Scanning from the highest offset down leaves the closest requester after rr_ptr as the winner.
    always_comb begin
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[rr_ptr + ID_W'(i)]) begin
                pick    = rr_ptr + ID_W'(i);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        rr_ptr_nx   = rr_ptr;
        cnt_nx      = cnt;
        timer_nx    = timer;
        word_idx_nx = word_idx;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    grant_nx  = pick;
                    rr_ptr_nx = pick + ID_W'(1);
                    cnt_nx    = '0;
                    state_nx  = LOAD;
                end
            end
            LOAD: begin
                if (lane_valid) begin
                    cnt_nx = cnt + 6'd1;
                    if (cnt == 6'd63) state_nx = START;
                end
            end
            START: begin
                timer_nx = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (bus.core_done) begin
                    word_idx_nx = '0;
                    state_nx    = OUT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nx = ERR;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            OUT: begin
                word_idx_nx = word_idx + 3'd1;
                if (word_idx == 3'd4) state_nx = IDLE;
            end
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            timer    <= '0;
            word_idx <= '0;
            digest   <= '0;
            block    <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            rr_ptr   <= rr_ptr_nx;
            cnt      <= cnt_nx;
            timer    <= timer_nx;
            word_idx <= word_idx_nx;
            // byte 0 lands in the top byte of the block, byte 63 in the bottom
            if (accept)  block[{~cnt, 3'b000} +: 8] <= lane_data;
            if (capture) digest <= bus.core_digest;
        end
    end

    always_comb begin
        out_word = '0;
        case (word_idx)
            3'd0:    out_word = digest[159:128];
            3'd1:    out_word = digest[127:96];
            3'd2:    out_word = digest[95:64];
            3'd3:    out_word = digest[63:32];
            3'd4:    out_word = digest[31:0];
            default: out_word = '0;
        endcase
    end

    assign rsp_active     = (state == OUT) || (state == ERR);
    assign bus.req_ready  = (state == LOAD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign bus.core_start = (state == START);
    assign bus.core_block = block;
    assign bus.rsp_valid  = rsp_active;
    assign bus.rsp_id     = rsp_active ? grant : '0;
    assign bus.rsp_word   = (state == OUT) ? out_word : '0;
    assign bus.rsp_last   = (state == ERR) || ((state == OUT) && (word_idx == 3'd4));
    assign bus.rsp_error  = (state == ERR);
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_hash160_arbiter.sv
// Directed bench for hash160_arbiter: grant, load, core handshake, response, timeout and reset.
// The bench plays host requesters and the hash core.
module tb_hash160_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hash160_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    hash160_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [159:0] dig = 160'h0123456789ABCDEF_FEDCBA98_76543210_DEADBEEF;

    int          got_id, ld_cycles, ld_n;
    bit          rdy_bad, early_start;
    int          first_off, nbeats;
    logic [31:0] rw  [6];
    logic [1:0]  rid [6];
    logic [5:0]  last_mask, err_mask;
    bit          idle_dirty;

    function automatic logic [511:0] exp_block(input logic [7:0] base);
        logic [511:0] b;
        for (int i = 0; i < 64; i++) b[511 - 8*i -: 8] = base + 8'(i);
        return b;
    endfunction

    function automatic logic [31:0] exp_word(input int b);
        return dig[159 - 32*b -: 32];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers vmask in the current (IDLE) cycle, then streams nbytes of base+n on whichever lane is granted.
    task automatic load_bytes(input logic [3:0] vmask, input logic [7:0] base, input int nbytes,
                              input int stall_at, input int stall_len);
        int  n = 0;
        int  cyc = 0;
        int  sc = 0;
        bit  acc;
        got_id = -1; rdy_bad = 0; early_start = 0;
        bus.req_valid = vmask;
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = base;
        while (n < nbytes && cyc < 600) begin
            if (bus.core_start) early_start = 1;
            if (bus.req_ready != 4'b0 && got_id < 0)
                for (int i = 3; i >= 0; i--) if (bus.req_ready[i]) got_id = i;
            if (got_id >= 0 && bus.req_ready != 4'b0 && bus.req_ready != (4'b1 << got_id)) rdy_bad = 1;
            acc = (got_id >= 0) && bus.req_ready[got_id] && bus.req_valid[got_id];
            tick;
            cyc++;
            if (acc) n++;
            if (got_id >= 0) begin
                if (n == stall_at && sc < stall_len) begin
                    bus.req_valid[got_id] = 1'b0;
                    sc++;
                end else begin
                    bus.req_valid[got_id] = 1'b1;
                end
                bus.req_data[got_id*8 +: 8] = base + 8'(n);
            end
        end
        if (got_id >= 0) bus.req_valid[got_id] = 1'b0;
        ld_cycles = cyc;
        ld_n      = n;
    endtask

    // Called in the START cycle (offset 0); pulses core_done at done_off (-1: never) and records beats.
    task automatic run_core(input int done_off);
        bit fin = 0;
        first_off = -1; nbeats = 0; last_mask = '0; err_mask = '0; idle_dirty = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            bus.core_done = (k == done_off);
            if (bus.rsp_valid) begin
                if (first_off < 0) first_off = k;
                if (nbeats < 6) begin
                    rw[nbeats]        = bus.rsp_word;
                    rid[nbeats]       = bus.rsp_id;
                    last_mask[nbeats] = bus.rsp_last;
                    err_mask[nbeats]  = bus.rsp_error;
                end
                nbeats++;
                fin = bus.rsp_last;
            end else if ({bus.rsp_id, bus.rsp_word, bus.rsp_last, bus.rsp_error} != '0) begin
                idle_dirty = 1;
            end
            tick;
        end
        bus.core_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_vec++; if ({bus.req_ready, bus.core_start, bus.rsp_valid, bus.rsp_id, bus.rsp_word,
                      bus.rsp_last, bus.rsp_error, bus.busy} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero ready=%b start=%b rsp_valid=%b busy=%b want all 0",
                              bus.req_ready, bus.core_start, bus.rsp_valid, bus.busy);
        end
        n_vec++; if (bus.core_block !== '0) begin
            n_err++; $display("FAIL reset_block: got %h want 0", bus.core_block);
        end
        rst_n = 1'b1;
        tick; tick;
        n_vec++; if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_no_request: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single;
        load_bytes(4'b0100, 8'h00, 64, -1, 0);
        n_vec++; if (got_id !== 2) begin n_err++; $display("FAIL single_grant: got %0d want 2", got_id); end
        n_vec++; if (ld_cycles !== 65) begin n_err++; $display("FAIL single_start_time: got t+%0d want t+65", ld_cycles); end
        n_vec++; if (bus.core_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", bus.core_start); end
        n_vec++; if (early_start) begin n_err++; $display("FAIL single_early_start: got 1 want 0"); end
        n_vec++; if (bus.core_block[511:504] !== 8'h00) begin n_err++; $display("FAIL single_byte0: got %h want 00", bus.core_block[511:504]); end
        n_vec++; if (bus.core_block[7:0] !== 8'h3F) begin n_err++; $display("FAIL single_byte63: got %h want 3f", bus.core_block[7:0]); end
        n_vec++; if (bus.core_block !== exp_block(8'h00)) begin n_err++; $display("FAIL single_block: got %h want %h", bus.core_block, exp_block(8'h00)); end
        run_core(10);
        tick;
        n_vec++; if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", bus.core_start); end
        n_vec++; if (first_off !== 11) begin n_err++; $display("FAIL single_rsp_latency: got %0d want 11", first_off); end
        n_vec++; if (nbeats !== 5) begin n_err++; $display("FAIL single_beats: got %0d want 5", nbeats); end
        for (int b = 0; b < 5; b++) begin
            n_vec++;
            if ({rw[b], rid[b], last_mask[b], err_mask[b]} !== {exp_word(b), 2'd2, (b == 4), 1'b0}) begin
                n_err++; $display("FAIL single_beat%0d: got word=%h id=%0d last=%b err=%b want word=%h id=2 last=%b err=0",
                                  b, rw[b], rid[b], last_mask[b], err_mask[b], exp_word(b), (b == 4));
            end
        end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_after: busy got %b want 0", bus.busy); end
        n_vec++; if (idle_dirty) begin n_err++; $display("FAIL single_rsp_quiet: got nonzero rsp fields without valid"); end
    endtask

    // The run_core above ended with an extra tick, so the arbiter has idled one more cycle here; harmless.
    task automatic test_round_robin;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        for (int g = 0; g < 5; g++) begin
            load_bytes(4'b1111, 8'h40 + 8'(16*g), 64, -1, 0);
            n_vec++; if (got_id !== g % 4) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", g, got_id, g % 4); end
            n_vec++; if (rdy_bad) begin n_err++; $display("FAIL rr_ready_onehot%0d: got non-one-hot ready want only lane %0d", g, g % 4); end
            n_vec++; if (ld_cycles !== 65) begin n_err++; $display("FAIL rr_turnaround%0d: got %0d want 65", g, ld_cycles); end
            run_core(2);
            n_vec++; if (nbeats !== 5 || rid[0] !== 2'(g % 4) || rid[4] !== 2'(g % 4)) begin
                n_err++; $display("FAIL rr_rsp%0d: got beats=%0d id=%0d want beats=5 id=%0d", g, nbeats, rid[0], g % 4);
            end
        end
    endtask

    task automatic test_stalled_load;
        load_bytes(4'b0001, 8'h80, 64, 11, 20);
        n_vec++; if (got_id !== 0) begin n_err++; $display("FAIL stall_grant: got %0d want 0", got_id); end
        n_vec++; if (early_start) begin n_err++; $display("FAIL stall_early_start: got 1 want 0"); end
        n_vec++; if (ld_cycles !== 85) begin n_err++; $display("FAIL stall_start_time: got t+%0d want t+85", ld_cycles); end
        n_vec++; if (bus.core_start !== 1'b1) begin n_err++; $display("FAIL stall_start: got %b want 1", bus.core_start); end
        n_vec++; if (bus.core_block !== exp_block(8'h80)) begin n_err++; $display("FAIL stall_block: got %h want %h", bus.core_block, exp_block(8'h80)); end
        run_core(5);
        n_vec++; if (first_off !== 6 || nbeats !== 5) begin n_err++; $display("FAIL stall_rsp: got off=%0d beats=%0d want off=6 beats=5", first_off, nbeats); end
        n_vec++; if (bus.core_block !== exp_block(8'h80)) begin n_err++; $display("FAIL stall_block_hold: got %h want %h", bus.core_block, exp_block(8'h80)); end
    endtask

    task automatic test_timeout;
        load_bytes(4'b1000, 8'h33, 64, -1, 0);
        n_vec++; if (got_id !== 3) begin n_err++; $display("FAIL tmo_grant: got %0d want 3", got_id); end
        run_core(-1);
        n_vec++; if (first_off !== 17) begin n_err++; $display("FAIL tmo_latency: got %0d want 17", first_off); end
        n_vec++; if (nbeats !== 1) begin n_err++; $display("FAIL tmo_beats: got %0d want 1", nbeats); end
        n_vec++; if ({rw[0], rid[0], last_mask[0], err_mask[0]} !== {32'h0, 2'd3, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL tmo_beat: got word=%h id=%0d last=%b err=%b want word=0 id=3 last=1 err=1",
                              rw[0], rid[0], last_mask[0], err_mask[0]);
        end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle_after: busy got %b want 0", bus.busy); end
        load_bytes(4'b1111, 8'h10, 64, -1, 0);
        n_vec++; if (got_id !== 0) begin n_err++; $display("FAIL tmo_next_grant: got %0d want 0", got_id); end
        run_core(2);
        n_vec++; if (nbeats !== 5 || err_mask !== 6'b0) begin n_err++; $display("FAIL tmo_next_rsp: got beats=%0d err=%b want 5 and 0", nbeats, err_mask); end
    endtask

    task automatic test_collision;
        load_bytes(4'b0010, 8'h20, 64, -1, 0);
        n_vec++; if (got_id !== 1) begin n_err++; $display("FAIL coll_grant: got %0d want 1", got_id); end
        run_core(16);
        n_vec++; if (first_off !== 17) begin n_err++; $display("FAIL coll_latency: got %0d want 17", first_off); end
        n_vec++; if (nbeats !== 5) begin n_err++; $display("FAIL coll_beats: got %0d want 5", nbeats); end
        n_vec++; if (err_mask !== 6'b0 || last_mask !== 6'b010000) begin
            n_err++; $display("FAIL coll_flags: got err=%b last=%b want err=000000 last=010000", err_mask, last_mask);
        end
        n_vec++; if (rw[0] !== exp_word(0) || rw[4] !== exp_word(4)) begin
            n_err++; $display("FAIL coll_words: got %h/%h want %h/%h", rw[0], rw[4], exp_word(0), exp_word(4));
        end
    endtask

    task automatic test_reset_mid_load;
        load_bytes(4'b0100, 8'h55, 30, -1, 0);
        n_vec++; if (got_id !== 2 || ld_n !== 30) begin n_err++; $display("FAIL mid_partial: got id=%0d bytes=%0d want id=2 bytes=30", got_id, ld_n); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.req_ready, bus.core_start, bus.rsp_valid, bus.rsp_id, bus.rsp_word,
                      bus.rsp_last, bus.rsp_error, bus.busy} !== '0 || bus.core_block !== '0) begin
            n_err++; $display("FAIL mid_reset_outputs: got ready=%b busy=%b block_nonzero=%b want all 0",
                              bus.req_ready, bus.busy, bus.core_block != '0);
        end
        tick;
        rst_n = 1'b1;
        tick;
        load_bytes(4'b1111, 8'hC0, 64, -1, 0);
        n_vec++; if (got_id !== 0) begin n_err++; $display("FAIL mid_rr_reset: got %0d want 0", got_id); end
        n_vec++; if (bus.core_block !== exp_block(8'hC0)) begin n_err++; $display("FAIL mid_block: got %h want %h", bus.core_block, exp_block(8'hC0)); end
        run_core(3);
        n_vec++; if (nbeats !== 5 || rid[0] !== 2'd0) begin n_err++; $display("FAIL mid_rsp: got beats=%0d id=%0d want 5 and 0", nbeats, rid[0]); end
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.core_done   = 1'b0;
        bus.core_digest = dig;
        test_reset();
        test_single();
        test_round_robin();
        test_stalled_load();
        test_timeout();
        test_collision();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
